// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one pipelined aes_128 core between two requesters.
// Each issued block carries its requester ID down a tag pipeline matched to the core latency.
module aes_core_arbiter #(
  parameter int LATENCY = 21,
  parameter int MAX_OUT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_state,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_state,
  input  logic [127:0] req1_key,
  output logic [127:0] core_state,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [127:0] rsp_data,
  output logic         busy
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_OUT);

  logic [CW-1:0]    out0_reg, out1_reg, out0_next, out1_next;
  logic             last_reg;
  logic [LATENCY:0] tag_valid_reg, tag_id_reg;
  logic [127:0]     core_state_reg, core_key_reg, rsp_data_reg;
  logic             rsp0_valid_reg, rsp1_valid_reg, busy_reg;
  logic             elig0, elig1, grant0, grant1, done0, done1;

  always_comb begin
    elig0  = rst & req0_valid & (out0_reg < CREDIT_MAX);
    elig1  = rst & req1_valid & (out1_reg < CREDIT_MAX);
    // On a tie the requester that did not win last time goes first.
    grant0 = elig0 & (~elig1 | last_reg);
    grant1 = elig1 & (~elig0 | ~last_reg);
    done0  = tag_valid_reg[LATENCY] & ~tag_id_reg[LATENCY];
    done1  = tag_valid_reg[LATENCY] & tag_id_reg[LATENCY];

    out0_next = out0_reg;
    if (grant0 & ~done0)
      out0_next = out0_reg + CW'(1);
    else if (~grant0 & done0)
      out0_next = out0_reg - CW'(1);

    out1_next = out1_reg;
    if (grant1 & ~done1)
      out1_next = out1_reg + CW'(1);
    else if (~grant1 & done1)
      out1_next = out1_reg - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out0_reg       <= '0;
      out1_reg       <= '0;
      last_reg       <= 1'b1;
      tag_valid_reg  <= '0;
      tag_id_reg     <= '0;
      core_state_reg <= '0;
      core_key_reg   <= '0;
      rsp_data_reg   <= '0;
      rsp0_valid_reg <= 1'b0;
      rsp1_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      out0_reg      <= out0_next;
      out1_reg      <= out1_next;
      tag_valid_reg <= {tag_valid_reg[LATENCY-1:0], grant0 | grant1};
      tag_id_reg    <= {tag_id_reg[LATENCY-1:0], grant1};
      if (grant0) begin
        last_reg       <= 1'b0;
        core_state_reg <= req0_state;
        core_key_reg   <= req0_key;
      end else if (grant1) begin
        last_reg       <= 1'b1;
        core_state_reg <= req1_state;
        core_key_reg   <= req1_key;
      end
      if (done0 | done1)
        rsp_data_reg <= core_out;
      rsp0_valid_reg <= done0;
      rsp1_valid_reg <= done1;
      busy_reg       <= (|tag_valid_reg) | (out0_reg != '0) | (out1_reg != '0);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign core_state = core_state_reg;
  assign core_key   = core_key_reg;
  assign rsp0_valid = rsp0_valid_reg;
  assign rsp1_valid = rsp1_valid_reg;
  assign rsp_data   = rsp_data_reg;
  assign busy       = busy_reg;

endmodule
